// File: rtl/cdc_bus_launch_if.sv
// Source-side bundle for the toggle-handshake bus launcher:
// word intake, launch bus, request/ack toggles and status.
interface cdc_bus_launch_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [WIDTH-1:0] xfer_data;
  logic             xfer_req;
  logic             xfer_ack;
  logic             busy;
  logic             timeout_err;

  modport master (
    output din, din_valid, xfer_ack,
    input  din_ready, xfer_data, xfer_req,
    input  busy, timeout_err
  );

  modport slave (
    input  din, din_valid, xfer_ack,
    output din_ready, xfer_data, xfer_req,
    output busy, timeout_err
  );
endinterface

// File: rtl/cdc_bus_launch.sv
// Launches a held multi-bit word across a clock boundary with a
// toggle request, then waits for the resynchronised ack toggle.
module cdc_bus_launch #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 2,
  parameter int ACK_TIMEOUT   = 0
) (
  input logic              clk,
  input logic              sclr,
  cdc_bus_launch_if.slave  bus
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] SCNT_INIT = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX = TW'(ACK_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST =
    TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam bit TO_EN = (ACK_TIMEOUT > 0);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("cdc_bus_launch: SETTLE_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_WAIT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;
  logic             r_req;
  logic             w_req_nxt;
  logic [SW-1:0]    r_scnt;
  logic [SW-1:0]    w_scnt_nxt;
  logic [TW-1:0]    r_tcnt;
  logic [TW-1:0]    w_tcnt_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_match;
  logic             w_ready;

  assign w_match = (bus.xfer_ack == r_req);
  assign w_ready = (r_state == S_IDLE) && w_match;

  assign bus.din_ready   = w_ready;
  assign bus.xfer_data   = r_data;
  assign bus.xfer_req    = r_req;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.timeout_err = r_err;

  always_ff @(posedge clk) begin
    if (sclr) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_req   <= 1'b0;
      r_scnt  <= '0;
      r_tcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_req   <= w_req_nxt;
      r_scnt  <= w_scnt_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_req_nxt   = r_req;
    w_scnt_nxt  = r_scnt;
    w_tcnt_nxt  = r_tcnt;
    w_err_nxt   = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (bus.din_valid && w_ready) begin
          w_data_nxt  = bus.din;
          w_scnt_nxt  = SCNT_INIT;
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_scnt == '0) begin
          w_req_nxt   = ~r_req;
          w_tcnt_nxt  = '0;
          w_state_nxt = S_WAIT;
        end else begin
          w_scnt_nxt = r_scnt - SW'(1);
        end
      end
      S_WAIT: begin
        if (w_match) begin
          w_state_nxt = S_IDLE;
        end else begin
          // saturating wait counter; the flag is sticky
          if (r_tcnt != TO_MAX) w_tcnt_nxt = r_tcnt + TW'(1);
          if (TO_EN && (r_tcnt == TO_LAST)) w_err_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_cdc_bus_launch.sv
// Randomised + directed bench for cdc_bus_launch against a
// cycle-count transaction model and a word scoreboard.
module tb_cdc_bus_launch;
  localparam int W  = 32;
  localparam int SC = 2;
  localparam int TO = 8;
  localparam int NW = 8;

  logic clk = 1'b0;
  logic sclr = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;

  logic ack_man = 1'b0;
  logic ack_echo = 1'b0;
  bit   echo = 1'b0;
  bit   sb_en = 1'b0;
  bit   mon_en = 1'b0;

  cdc_bus_launch_if #(.WIDTH(W)) bus ();

  cdc_bus_launch #(
    .WIDTH(W),
    .SETTLE_CYCLES(SC),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .sclr(sclr),
    .bus(bus)
  );

  assign bus.xfer_ack = echo ? ack_echo : ack_man;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // transaction model: phases tracked by edge counts
  bit           m_busy = 0;
  bit           m_tog = 0;
  bit           m_req = 0;
  bit           m_err = 0;
  bit           m_acc = 0;
  logic [W-1:0] m_data = '0;
  int           m_left = 0;
  int           m_wait = 0;
  logic [W-1:0] rx_q[$];
  bit           rq_q[$];

  always @(posedge clk) begin
    m_acc = 0;
    if (sclr) begin
      m_busy = 0; m_tog = 0; m_req = 0; m_err = 0;
      m_data = '0; m_left = 0; m_wait = 0;
    end else if (!m_busy) begin
      if (bus.din_valid && (bus.xfer_ack == m_req)) begin
        m_data = bus.din;
        m_busy = 1;
        m_tog  = 0;
        m_left = SC;
        m_acc  = 1;
      end
    end else if (!m_tog) begin
      m_left--;
      if (m_left == 0) begin
        m_req  = !m_req;
        m_tog  = 1;
        m_wait = 0;
      end
    end else if (bus.xfer_ack == m_req) begin
      m_busy = 0;
    end else begin
      m_wait++;
      if (m_wait >= TO) m_err = 1;
    end
  end

  // destination echo: ack follows req after a few cycles
  logic [3:0] rq_hist = '0;
  always @(negedge clk) rq_hist <= {rq_hist[2:0], bus.xfer_req};
  always @(posedge clk) begin
    #1;
    ack_echo = rq_hist[3];
  end

  logic         p_busy = 0;
  logic         p_sclr = 1;
  logic         p_req = 0;
  logic [W-1:0] p_data = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("ready", bus.din_ready,
          !m_busy && (bus.xfer_ack == m_req));
      chk("data", bus.xfer_data, m_data);
      chk("req", bus.xfer_req, m_req);
      chk("busy", bus.busy, m_busy);
      chk("terr", bus.timeout_err, m_err);
      if (p_busy && !p_sclr) chk("hold", bus.xfer_data, p_data);
    end
    if (bus.xfer_req !== p_req) begin
      if (sb_en) begin
        rx_q.push_back(bus.xfer_data);
        rq_q.push_back(bus.xfer_req);
      end
      p_req = bus.xfer_req;
    end
    p_busy = bus.busy;
    p_data = bus.xfer_data;
    p_sclr = sclr;
  end

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((m_busy || bus.busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", k < budget, 1);
  endtask

  task automatic wait_toggle(input int budget);
    int   k = 0;
    logic r0 = bus.xfer_req;
    do begin
      @(negedge clk);
      k++;
    end while (bus.xfer_req == r0 && k < budget);
    chk("toggle_wait", bus.xfer_req != r0, 1);
  endtask

  logic [W-1:0] words[NW];
  int           idx;
  int           nchk;

  initial begin
    bus.din = '0;
    bus.din_valid = 1'b0;
    sclr = 1'b1;
    repeat (3) tick();
    sclr = 1'b0;
    @(negedge clk);
    chk("rst_data", bus.xfer_data, 0);
    chk("rst_req", bus.xfer_req, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_terr", bus.timeout_err, 0);
    chk("rst_ready", bus.din_ready, 1);
    mon_en = 1;

    // single word, manual ack
    tick();
    bus.din = 32'hA5A5_0001;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    bus.din = 32'h1111_2222;
    @(negedge clk);
    chk("t1_data", bus.xfer_data, 32'hA5A5_0001);
    chk("t1_req0", bus.xfer_req, 0);
    tick();
    @(negedge clk);
    chk("t1_req1", bus.xfer_req, 0);
    tick();
    @(negedge clk);
    chk("t1_req2", bus.xfer_req, 1);
    chk("t1_nrdy", bus.din_ready, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("t1_nrdy2", bus.din_ready, 0);
    tick();
    ack_man = 1'b1;
    @(negedge clk);
    chk("t1_nrdy3", bus.din_ready, 0);
    tick();
    @(negedge clk);
    chk("t1_rdy", bus.din_ready, 1);

    // back-to-back with echoed ack
    tick();
    sclr = 1'b1;
    ack_man = 1'b0;
    repeat (6) tick();
    sclr = 1'b0;
    echo = 1;
    sb_en = 1;
    words[0] = 1;
    words[1] = 2;
    words[2] = 3;
    for (int i = 3; i < NW; i++) words[i] = $urandom;
    idx = 0;
    bus.din = words[0];
    bus.din_valid = 1'b1;
    for (int c = 0; c < 400 && idx < NW; c++) begin
      tick();
      if (m_acc) begin
        idx++;
        if (idx < NW) bus.din = words[idx];
        else bus.din_valid = 1'b0;
      end
    end
    chk("b2b_sent", idx, NW);
    wait_idle(60);
    sb_en = 0;
    chk("b2b_count", rx_q.size(), NW);
    nchk = (rx_q.size() < NW) ? rx_q.size() : NW;
    for (int i = 0; i < nchk; i++) begin
      chk($sformatf("b2b_word%0d", i), rx_q[i], words[i]);
      chk($sformatf("b2b_req%0d", i), rq_q[i], (i % 2) == 0);
    end

    // random traffic, din changing every cycle
    for (int c = 0; c < 120; c++) begin
      tick();
      bus.din = $urandom;
      bus.din_valid = $urandom_range(0, 1);
    end
    tick();
    bus.din_valid = 1'b0;
    wait_idle(60);

    // timeout: never ack
    tick();
    ack_man = bus.xfer_req;
    echo = 0;
    bus.din = 32'hDEAD_0008;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    wait_toggle(10);
    repeat (7) @(negedge clk);
    chk("to_pre", bus.timeout_err, 0);
    @(negedge clk);
    chk("to_set", bus.timeout_err, 1);
    repeat (5) @(negedge clk);
    chk("to_sticky", bus.timeout_err, 1);
    chk("to_busy", bus.busy, 1);
    tick();
    ack_man = bus.xfer_req;
    tick();
    @(negedge clk);
    chk("to_late_idle", bus.busy, 0);
    chk("to_late_err", bus.timeout_err, 1);
    chk("to_late_rdy", bus.din_ready, 1);

    // reset mid-WAIT_ACK with ack already returned high
    tick();
    sclr = 1'b1;
    ack_man = 1'b0;
    repeat (2) tick();
    sclr = 1'b0;
    @(negedge clk);
    chk("rs_err_clr", bus.timeout_err, 0);
    tick();
    bus.din = 32'h5A5A_1234;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    wait_toggle(10);
    chk("rs_req1", bus.xfer_req, 1);
    tick();
    ack_man = 1'b1;
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    bus.din = 32'h7777_0000;
    bus.din_valid = 1'b1;
    @(negedge clk);
    chk("rs_req", bus.xfer_req, 0);
    chk("rs_data", bus.xfer_data, 0);
    chk("rs_err", bus.timeout_err, 0);
    chk("rs_nrdy", bus.din_ready, 0);
    repeat (4) tick();
    @(negedge clk);
    chk("rs_nrdy2", bus.din_ready, 0);
    chk("rs_nbusy", bus.busy, 0);
    tick();
    ack_man = 1'b0;
    bus.din_valid = 1'b0;
    @(negedge clk);
    chk("rs_rdy", bus.din_ready, 1);

    // spurious ack toggle while idle
    tick();
    ack_man = 1'b1;
    bus.din = 32'h0BAD_F00D;
    bus.din_valid = 1'b1;
    @(negedge clk);
    chk("sp_nrdy", bus.din_ready, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("sp_nbusy", bus.busy, 0);
    chk("sp_data", bus.xfer_data, 0);
    tick();
    ack_man = 1'b0;
    @(negedge clk);
    chk("sp_rdy", bus.din_ready, 1);
    tick();
    bus.din_valid = 1'b0;
    @(negedge clk);
    chk("sp_acc", bus.xfer_data, 32'h0BAD_F00D);
    chk("sp_busy", bus.busy, 1);
    wait_toggle(10);
    tick();
    ack_man = 1'b1;
    wait_idle(10);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
